// File: rtl/btb_tagged.sv
// Set-associative, partially tagged branch target buffer with round-robin
// victim selection and a sequential set-by-set flush engine.

module btb_tagged_slot #(
  parameter int unsigned NR_SETS  = 16,
  parameter int unsigned NR_WAYS  = 2,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned VLEN     = 64,
  parameter int unsigned XB       = 4,
  parameter int unsigned WW       = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [XB-1:0]       lk_set,
  input  logic [TAG_BITS-1:0] lk_tag,
  output logic                hit,
  output logic [VLEN-1:0]     target,
  input  logic                upd_en,
  input  logic                upd_clear,
  input  logic [XB-1:0]       upd_set,
  input  logic [TAG_BITS-1:0] upd_tag,
  input  logic [VLEN-1:0]     upd_target,
  input  logic [WW-1:0]       upd_ptr,
  output logic                evict,
  input  logic                flush_en,
  input  logic [XB-1:0]       flush_set
);

  logic [NR_SETS-1:0][NR_WAYS-1:0] valid_q;
  logic [NR_WAYS-1:0][TAG_BITS-1:0] tag_q [NR_SETS];
  logic [NR_WAYS-1:0][VLEN-1:0]     tgt_q [NR_SETS];

  logic          u_hit, u_inv;
  logic [WW-1:0] u_hit_way, u_inv_way, wr_way;

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit    = 1'b0;
    target = '0;
    for (int w = NR_WAYS-1; w >= 0; w--) begin
      if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
        hit    = 1'b1;
        target = tgt_q[lk_set][w];
      end
    end
  end

  always_comb begin
    u_hit     = 1'b0;
    u_inv     = 1'b0;
    u_hit_way = '0;
    u_inv_way = '0;
    for (int w = NR_WAYS-1; w >= 0; w--) begin
      if (valid_q[upd_set][w] && tag_q[upd_set][w] == upd_tag) begin
        u_hit     = 1'b1;
        u_hit_way = WW'(w);
      end
      if (!valid_q[upd_set][w]) begin
        u_inv     = 1'b1;
        u_inv_way = WW'(w);
      end
    end
    wr_way = u_hit ? u_hit_way : (u_inv ? u_inv_way : upd_ptr);
    evict  = upd_en && !upd_clear && !u_hit && !u_inv;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush_en) begin
      valid_q[flush_set] <= '0;
    end else if (upd_en) begin
      if (upd_clear) begin
        if (u_hit) valid_q[upd_set][u_hit_way] <= 1'b0;
      end else begin
        valid_q[upd_set][wr_way] <= 1'b1;
      end
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (upd_en && !upd_clear) begin
      tag_q[upd_set][wr_way] <= upd_tag;
      tgt_q[upd_set][wr_way] <= upd_target;
    end
  end

endmodule

module btb_tagged #(
  parameter int unsigned NR_ENTRIES      = 64,
  parameter int unsigned NR_WAYS         = 2,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned TAG_BITS        = 8,
  parameter int unsigned VLEN            = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            debug_mode_i,
  input  logic [VLEN-1:0]                 vpc_i,
  input  logic                            update_valid_i,
  input  logic [VLEN-1:0]                 update_pc_i,
  input  logic [VLEN-1:0]                 update_target_i,
  input  logic                            update_clear_i,
  output logic [INSTR_PER_FETCH-1:0]      pred_valid_o,
  output logic [INSTR_PER_FETCH*VLEN-1:0] pred_target_o,
  output logic                            flush_busy_o
);

  localparam int unsigned NR_SETS = NR_ENTRIES / (NR_WAYS * INSTR_PER_FETCH);
  localparam int unsigned SB      = $clog2(INSTR_PER_FETCH);
  localparam int unsigned XB      = $clog2(NR_SETS);
  localparam int unsigned SW      = (SB > 0) ? SB : 1;
  localparam int unsigned WW      = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

  function automatic logic [SW-1:0] slot_of(input logic [VLEN-1:0] pc);
    logic [VLEN-1:0] s;
    s = pc >> 1;
    return (SB > 0) ? s[SW-1:0] : '0;
  endfunction

  function automatic logic [XB-1:0] set_of(input logic [VLEN-1:0] pc);
    logic [VLEN-1:0] s;
    s = pc >> (SB + 1);
    return s[XB-1:0];
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_of(input logic [VLEN-1:0] pc);
    logic [VLEN-1:0] s;
    s = pc >> (SB + XB + 1);
    return s[TAG_BITS-1:0];
  endfunction

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [XB-1:0] cnt_q, cnt_d;
  logic          flush_en, upd_acc;

  logic [SW-1:0]       upd_slot;
  logic [XB-1:0]       upd_set, lk_set;
  logic [TAG_BITS-1:0] upd_tag, lk_tag;
  logic [WW-1:0]       upd_ptr;

  logic [INSTR_PER_FETCH-1:0]           slot_hit, evict;
  logic [INSTR_PER_FETCH-1:0][VLEN-1:0] slot_tgt;

  assign upd_slot = slot_of(update_pc_i);
  assign upd_set  = set_of(update_pc_i);
  assign upd_tag  = tag_of(update_pc_i);
  assign lk_set   = set_of(vpc_i);
  assign lk_tag   = tag_of(vpc_i);

  assign flush_en     = (state_q == FLUSH);
  assign flush_busy_o = flush_en;
  // A flush request in the same cycle takes priority over the update.
  assign upd_acc = update_valid_i && !debug_mode_i && (state_q == IDLE) && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + XB'(1);
        if (cnt_q == XB'(NR_SETS-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    if (NR_WAYS > 1) begin : g_ptr
      logic [NR_SETS-1:0][WW-1:0] ptr_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       ptr_q <= '0;
        else if (flush_en) ptr_q[cnt_q] <= '0;
        else if (|evict)   ptr_q[upd_set] <= ptr_q[upd_set] + WW'(1);
      end
      assign upd_ptr = ptr_q[upd_set];
    end else begin : g_no_ptr
      assign upd_ptr = '0;
    end
  endgenerate

  for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_slot
    btb_tagged_slot #(
      .NR_SETS (NR_SETS),
      .NR_WAYS (NR_WAYS),
      .TAG_BITS(TAG_BITS),
      .VLEN    (VLEN),
      .XB      (XB),
      .WW      (WW)
    ) u_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .lk_set    (lk_set),
      .lk_tag    (lk_tag),
      .hit       (slot_hit[i]),
      .target    (slot_tgt[i]),
      .upd_en    (upd_acc && (upd_slot == SW'(i))),
      .upd_clear (update_clear_i),
      .upd_set   (upd_set),
      .upd_tag   (upd_tag),
      .upd_target(update_target_i),
      .upd_ptr   (upd_ptr),
      .evict     (evict[i]),
      .flush_en  (flush_en),
      .flush_set (cnt_q)
    );
    assign pred_valid_o[i]              = slot_hit[i] && !flush_busy_o;
    assign pred_target_o[i*VLEN +: VLEN] = slot_tgt[i];
  end

endmodule

// File: tb/tb_btb_tagged.sv
// Directed bench for btb_tagged: lookup, aliasing, replacement, clear,
// debug suppression, flush timing and reset during flush.

module tb_btb_tagged;

  logic         clk_i = 1'b0;
  logic         rst_ni, flush_i, debug_mode_i, update_valid_i, update_clear_i;
  logic [63:0]  vpc_i, update_pc_i, update_target_i;
  logic [1:0]   pred_valid_o;
  logic [127:0] pred_target_o;
  logic         flush_busy_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  btb_tagged dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .debug_mode_i   (debug_mode_i),
    .vpc_i          (vpc_i),
    .update_valid_i (update_valid_i),
    .update_pc_i    (update_pc_i),
    .update_target_i(update_target_i),
    .update_clear_i (update_clear_i),
    .pred_valid_o   (pred_valid_o),
    .pred_target_o  (pred_target_o),
    .flush_busy_o   (flush_busy_o)
  );

  task automatic do_reset();
    rst_ni = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0; update_valid_i = 1'b0;
    update_clear_i = 1'b0; update_pc_i = '0; update_target_i = '0; vpc_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic clr, input logic dbg);
    update_valid_i = 1'b1; update_pc_i = pc; update_target_i = tgt;
    update_clear_i = clr; debug_mode_i = dbg;
    @(posedge clk_i); #1;
    update_valid_i = 1'b0; update_clear_i = 1'b0; debug_mode_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vpc_i = 64'h8000_0004; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL reset_valid: got %b expected 00", pred_valid_o); end
    vec_cnt++; if (flush_busy_o !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", flush_busy_o); end
    vec_cnt++; if (pred_target_o !== 128'h0) begin err_cnt++; $display("FAIL reset_target: got %h expected 0", pred_target_o); end
  endtask

  task automatic test_hit_alias();
    do_reset();
    vpc_i = 64'h8000_0004;
    update_valid_i = 1'b1; update_pc_i = 64'h8000_0004; update_target_i = 64'h8000_0100;
    #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL same_cycle_old: got %b expected 00", pred_valid_o); end
    @(posedge clk_i); #1; update_valid_i = 1'b0; #1;
    vec_cnt++; if (pred_valid_o !== 2'b01) begin err_cnt++; $display("FAIL hit_valid: got %b expected 01", pred_valid_o); end
    vec_cnt++; if (pred_target_o[63:0] !== 64'h8000_0100) begin err_cnt++; $display("FAIL hit_target: got %h expected 80000100", pred_target_o[63:0]); end
    vec_cnt++; if (pred_target_o[127:64] !== 64'h0) begin err_cnt++; $display("FAIL miss_target_zero: got %h expected 0", pred_target_o[127:64]); end
    vpc_i = 64'h8000_0044; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL alias_reject: got %b expected 00", pred_valid_o); end
    upd(64'h8000_0006, 64'h8000_0500, 1'b0, 1'b0);
    vpc_i = 64'h8000_0004; #1;
    vec_cnt++; if (pred_valid_o !== 2'b11) begin err_cnt++; $display("FAIL slot1_valid: got %b expected 11", pred_valid_o); end
    vec_cnt++; if (pred_target_o[127:64] !== 64'h8000_0500) begin err_cnt++; $display("FAIL slot1_target: got %h expected 80000500", pred_target_o[127:64]); end
  endtask

  task automatic test_replacement();
    do_reset();
    upd(64'h8000_0004, 64'h100, 1'b0, 1'b0);
    upd(64'h8000_0044, 64'h200, 1'b0, 1'b0);
    upd(64'h8000_0084, 64'h300, 1'b0, 1'b0);
    vpc_i = 64'h8000_0004; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL evict_way0: got %b expected 00", pred_valid_o); end
    vpc_i = 64'h8000_0044; #1;
    vec_cnt++; if (pred_valid_o !== 2'b01 || pred_target_o[63:0] !== 64'h200) begin err_cnt++; $display("FAIL keep_44: got %b/%h expected 01/200", pred_valid_o, pred_target_o[63:0]); end
    vpc_i = 64'h8000_0084; #1;
    vec_cnt++; if (pred_valid_o !== 2'b01 || pred_target_o[63:0] !== 64'h300) begin err_cnt++; $display("FAIL new_84: got %b/%h expected 01/300", pred_valid_o, pred_target_o[63:0]); end
    upd(64'h8000_00C4, 64'h400, 1'b0, 1'b0);
    vpc_i = 64'h8000_0044; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL evict_way1: got %b expected 00", pred_valid_o); end
    vpc_i = 64'h8000_00C4; #1;
    vec_cnt++; if (pred_valid_o !== 2'b01 || pred_target_o[63:0] !== 64'h400) begin err_cnt++; $display("FAIL new_c4: got %b/%h expected 01/400", pred_valid_o, pred_target_o[63:0]); end
    // Tag-hit overwrite must leave the pointer at way0.
    upd(64'h8000_0084, 64'h380, 1'b0, 1'b0);
    vpc_i = 64'h8000_0084; #1;
    vec_cnt++; if (pred_target_o[63:0] !== 64'h380) begin err_cnt++; $display("FAIL overwrite: got %h expected 380", pred_target_o[63:0]); end
    upd(64'h8000_0004, 64'h500, 1'b0, 1'b0);
    vpc_i = 64'h8000_0084; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL ptr_hold_evict: got %b expected 00", pred_valid_o); end
    vpc_i = 64'h8000_00C4; #1;
    vec_cnt++; if (pred_valid_o !== 2'b01) begin err_cnt++; $display("FAIL ptr_hold_keep: got %b expected 01", pred_valid_o); end
  endtask

  task automatic test_clear_debug();
    do_reset();
    upd(64'h8000_0004, 64'h100, 1'b0, 1'b0);
    upd(64'h8000_0044, 64'h200, 1'b0, 1'b0);
    upd(64'h8000_0084, 64'h300, 1'b0, 1'b0);
    upd(64'h8000_0044, 64'h0, 1'b1, 1'b0);
    vpc_i = 64'h8000_0044; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL clear_hit: got %b expected 00", pred_valid_o); end
    vpc_i = 64'h8000_0084; #1;
    vec_cnt++; if (pred_valid_o !== 2'b01 || pred_target_o[63:0] !== 64'h300) begin err_cnt++; $display("FAIL clear_other: got %b/%h expected 01/300", pred_valid_o, pred_target_o[63:0]); end
    upd(64'h8000_0104, 64'h0, 1'b1, 1'b0);
    #1;
    vec_cnt++; if (pred_valid_o !== 2'b01) begin err_cnt++; $display("FAIL clear_miss_noop: got %b expected 01", pred_valid_o); end
    upd(64'h8000_0084, 64'h999, 1'b0, 1'b1);
    #1;
    vec_cnt++; if (pred_target_o[63:0] !== 64'h300) begin err_cnt++; $display("FAIL debug_overwrite: got %h expected 300", pred_target_o[63:0]); end
    upd(64'h8000_0004, 64'h777, 1'b0, 1'b1);
    vpc_i = 64'h8000_0004; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL debug_alloc: got %b expected 00", pred_valid_o); end
  endtask

  task automatic test_flush();
    int busy;
    do_reset();
    upd(64'h8000_0004, 64'h100, 1'b0, 1'b0);
    upd(64'h8000_0008, 64'h200, 1'b0, 1'b0);
    upd(64'h8000_0010, 64'h300, 1'b0, 1'b0);
    upd(64'h8000_003C, 64'h400, 1'b0, 1'b0);
    vpc_i = 64'h8000_0004;
    flush_i = 1'b1;
    update_valid_i = 1'b1; update_pc_i = 64'h8000_0020; update_target_i = 64'h600;
    #1;
    vec_cnt++; if (flush_busy_o !== 1'b0 || pred_valid_o !== 2'b01) begin err_cnt++; $display("FAIL flush_req_cycle: got %b/%b expected 0/01", flush_busy_o, pred_valid_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b0; update_valid_i = 1'b0;
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      if (!flush_busy_o) break;
      busy++;
      vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL flush_pred_forced: cycle %0d got %b expected 00", busy, pred_valid_o); end
      flush_i = (busy == 3);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
    end
    vec_cnt++; if (busy != 16) begin err_cnt++; $display("FAIL flush_len: got %0d expected 16", busy); end
    vpc_i = 64'h8000_0004; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL post_flush_04: got %b expected 00", pred_valid_o); end
    vpc_i = 64'h8000_0008; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL post_flush_08: got %b expected 00", pred_valid_o); end
    vpc_i = 64'h8000_0010; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL post_flush_10: got %b expected 00", pred_valid_o); end
    vpc_i = 64'h8000_003C; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL post_flush_3c: got %b expected 00", pred_valid_o); end
    vpc_i = 64'h8000_0020; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL dropped_update: got %b expected 00", pred_valid_o); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    upd(64'h8000_0004, 64'h100, 1'b0, 1'b0);
    upd(64'h8000_003C, 64'h400, 1'b0, 1'b0);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    vec_cnt++; if (flush_busy_o !== 1'b1) begin err_cnt++; $display("FAIL mid_flush_busy: got %b expected 1", flush_busy_o); end
    rst_ni = 1'b0; #1;
    vec_cnt++; if (flush_busy_o !== 1'b0) begin err_cnt++; $display("FAIL rst_busy_drop: got %b expected 0", flush_busy_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    vec_cnt++; if (flush_busy_o !== 1'b0) begin err_cnt++; $display("FAIL rst_release_busy: got %b expected 0", flush_busy_o); end
    vpc_i = 64'h8000_003C; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL rst_clear_3c: got %b expected 00", pred_valid_o); end
    vpc_i = 64'h8000_0004; #1;
    vec_cnt++; if (pred_valid_o !== 2'b00) begin err_cnt++; $display("FAIL rst_clear_04: got %b expected 00", pred_valid_o); end
    upd(64'h8000_0044, 64'h700, 1'b0, 1'b0);
    vpc_i = 64'h8000_0044; #1;
    vec_cnt++; if (pred_valid_o !== 2'b01 || pred_target_o[63:0] !== 64'h700) begin err_cnt++; $display("FAIL post_rst_update: got %b/%h expected 01/700", pred_valid_o, pred_target_o[63:0]); end
  endtask

  initial begin
    test_reset();
    test_hit_alias();
    test_replacement();
    test_clear_debug();
    test_flush();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
